date_counter: RTL and testbench

- Calendar stage downstream of the hours counter. Consumes the hours counter's day-rollover output and maintains day-of-month, month and two-digit year (2000–2099).
- The hours counter runs on its own increment strobe, so its rollover signal is asynchronous to clk. This block synchronises it and advances once per rising edge.
- Also accepts a validated date load from the time-setting logic.

---
 rtl/date_pkg.sv | 53 +++++
 rtl/date_counter_edge_sync.sv | 39 +++
 rtl/date_counter.sv | 110 +++++++++++
 tb/tb_date_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/date_pkg.sv
// ============================================================================
// date_pkg : calendar widths, month codes and month-length lookup.
// Macro DATE_COUNTER_LEAP_YEAR_EN enables 29-day February. Rev 1.0
// ============================================================================
`default_nettype none

package date_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 7;

  localparam logic [MONTH_W-1:0] JAN = 4'd1;
  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MAR = 4'd3;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] MAY = 4'd5;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] JUL = 4'd7;
  localparam logic [MONTH_W-1:0] AUG = 4'd8;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] OCT = 4'd10;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;

  localparam logic [DAY_W-1:0]   RST_DAY   = 5'd1;
  localparam logic [MONTH_W-1:0] RST_MONTH = JAN;

`ifdef DATE_COUNTER_LEAP_YEAR_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif

  // Returns 0 for an out-of-range month so any day compares as invalid.
  function automatic logic [DAY_W-1:0] days_in_month(
    input logic [MONTH_W-1:0] month,
    input logic [YEAR_W-1:0]  year
  );
    logic [DAY_W-1:0] days;
    days = 5'd0;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: days = 5'd31;
      APR, JUN, SEP, NOV:                days = 5'd30;
      FEB: days = (LEAP_EN && (year[1:0] == 2'b00)) ? 5'd29 : 5'd28;
      default:                           days = 5'd0;
    endcase
    return days;
  endfunction

endpackage

`default_nettype wire

// File: rtl/date_counter_edge_sync.sv
// ============================================================================
// edge_sync : STAGES-flop synchroniser followed by a rising-edge detector.
// Rev 1.0
// ============================================================================
`default_nettype none

module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic [STAGES:0]   r_valid;
  logic              r_prev;

  // r_valid masks the edge detector until both the chain output and r_prev
  // hold genuine post-reset samples, so a level already high at reset
  // release is not mistaken for a new rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_valid <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[STAGES-2:0], i_async};
      r_valid <= {r_valid[STAGES-1:0], 1'b1};
      r_prev  <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev & r_valid[STAGES];

endmodule

`default_nettype wire

// File: rtl/date_counter.sv
// ============================================================================
// date_counter : day/month/year (2000-2099) calendar advanced by the hours
// counter rollover, with validated date load. Option: DATE_COUNTER_LEAP_YEAR_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module date_counter
  import date_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RST_YEAR    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_inc_day,
  input  logic               i_set_valid,
  input  logic [DAY_W-1:0]   i_set_day,
  input  logic [MONTH_W-1:0] i_set_month,
  input  logic [YEAR_W-1:0]  i_set_year,
  output logic               o_set_ack,
  output logic               o_set_err,
  output logic [DAY_W-1:0]   o_day,
  output logic [MONTH_W-1:0] o_month,
  output logic [YEAR_W-1:0]  o_year,
  output logic               o_inc_century
);

  logic [DAY_W-1:0]   r_day;
  logic [MONTH_W-1:0] r_month;
  logic [YEAR_W-1:0]  r_year;
  logic               r_set_ack;
  logic               r_set_err;
  logic               r_inc_century;

  logic               w_adv;
  logic [DAY_W-1:0]   w_len;
  logic [DAY_W-1:0]   w_set_len;
  logic               w_set_ok;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_inc_day),
    .o_rise  (w_adv)
  );

  assign w_len     = days_in_month(r_month, r_year);
  assign w_set_len = days_in_month(i_set_month, i_set_year);

  assign w_set_ok = (i_set_month != 4'd0) && (i_set_month <= DEC) &&
                    (i_set_year <= 7'd99) &&
                    (i_set_day != 5'd0) && (i_set_day <= w_set_len);

  // An accepted load overrides and discards a coincident advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_day         <= RST_DAY;
      r_month       <= RST_MONTH;
      r_year        <= YEAR_W'(RST_YEAR);
      r_set_ack     <= 1'b0;
      r_set_err     <= 1'b0;
      r_inc_century <= 1'b0;
    end else begin
      r_set_ack     <= 1'b0;
      r_set_err     <= 1'b0;
      r_inc_century <= 1'b0;
      if (i_set_valid && w_set_ok) begin
        r_day     <= i_set_day;
        r_month   <= i_set_month;
        r_year    <= i_set_year;
        r_set_ack <= 1'b1;
      end else begin
        if (i_set_valid) begin
          r_set_err <= 1'b1;
        end
        if (w_adv) begin
          if (r_day < w_len) begin
            r_day <= r_day + 1'b1;
          end else begin
            r_day <= RST_DAY;
            if (r_month == DEC) begin
              r_month <= JAN;
              if (r_year == 7'd99) begin
                r_year        <= '0;
                r_inc_century <= 1'b1;
              end else begin
                r_year <= r_year + 1'b1;
              end
            end else begin
              r_month <= r_month + 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_day         = r_day;
  assign o_month       = r_month;
  assign o_year        = r_year;
  assign o_set_ack     = r_set_ack;
  assign o_set_err     = r_set_err;
  assign o_inc_century = r_inc_century;

endmodule

`default_nettype wire

// File: tb/tb_date_counter.sv
// ============================================================================
// tb_date_counter : directed plus randomized checks of date_counter against an
// integer calendar model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_date_counter;

  localparam int SYNC  = 2;
  localparam int RST_Y = 0;
`ifdef DATE_COUNTER_LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       i_inc_day;
  logic       i_set_valid;
  logic [4:0] i_set_day;
  logic [3:0] i_set_month;
  logic [6:0] i_set_year;
  logic       o_set_ack;
  logic       o_set_err;
  logic [4:0] o_day;
  logic [3:0] o_month;
  logic [6:0] o_year;
  logic       o_inc_century;

  int total = 0;
  int bad   = 0;
  int md, mm, my;

  always #5 clk = ~clk;

  date_counter #(
    .SYNC_STAGES (SYNC),
    .RST_YEAR    (RST_Y)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_inc_day     (i_inc_day),
    .i_set_valid   (i_set_valid),
    .i_set_day     (i_set_day),
    .i_set_month   (i_set_month),
    .i_set_year    (i_set_year),
    .o_set_ack     (o_set_ack),
    .o_set_err     (o_set_err),
    .o_day         (o_day),
    .o_month       (o_month),
    .o_year        (o_year),
    .o_inc_century (o_inc_century)
  );

  function automatic int mlen(int m, int y);
    if (m == 2) return (LEAP && (y % 4 == 0)) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic eack, logic eerr, logic ecen);
    logic [18:0] obs;
    logic [18:0] exp;
    obs = {o_day, o_month, o_year, o_set_ack, o_set_err, o_inc_century};
    exp = {5'(md), 4'(mm), 7'(my), eack, eerr, ecen};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d/%0d/%0d ack=%b err=%b cen=%b, expected %0d/%0d/%0d ack=%b err=%b cen=%b",
             tag, o_day, o_month, o_year, o_set_ack, o_set_err, o_inc_century,
             md, mm, my, eack, eerr, ecen);
    end
  endtask

  task automatic model_adv(output logic cen);
    cen = 1'b0;
    if (md < mlen(mm, my)) begin
      md++;
    end else begin
      md = 1;
      if (mm == 12) begin
        mm = 1;
        if (my == 99) begin
          my  = 0;
          cen = 1'b1;
        end else begin
          my++;
        end
      end else begin
        mm++;
      end
    end
  endtask

  // Raise i_inc_day and hold it for 10 cycles; the date moves on the 3rd edge.
  task automatic pulse(string tag);
    logic cen;
    i_inc_day = 1'b1;
    tick();
    tick();
    check({tag, "_pre"}, 1'b0, 1'b0, 1'b0);
    tick();
    model_adv(cen);
    check(tag, 1'b0, 1'b0, cen);
    tick();
    check({tag, "_post"}, 1'b0, 1'b0, 1'b0);
    repeat (6) tick();
    i_inc_day = 1'b0;
    repeat (3) tick();
    check({tag, "_hold"}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(string tag, int d, int m, int y);
    logic ok;
    ok = (m >= 1) && (m <= 12) && (y <= 99) && (d >= 1) && (d <= mlen(m, y));
    i_set_valid = 1'b1;
    i_set_day   = 5'(d);
    i_set_month = 4'(m);
    i_set_year  = 7'(y);
    tick();
    i_set_valid = 1'b0;
    if (ok) begin
      md = d;
      mm = m;
      my = y;
    end
    check(tag, ok, !ok, 1'b0);
    tick();
    check({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic cen;
    int   sel;
    rst         = 1'b1;
    i_inc_day   = 1'b0;
    i_set_valid = 1'b0;
    i_set_day   = '0;
    i_set_month = '0;
    i_set_year  = '0;
    md = 1; mm = 1; my = RST_Y;
    repeat (2) tick();
    check("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (4) tick();
    check("reset_idle", 1'b0, 1'b0, 1'b0);

    pulse("first_adv");

    load("ld_31dec99", 31, 12, 99);
    pulse("century");

    load("ld_28feb24", 28, 2, 24);
    pulse("feb24_adv");
    load("ld_28feb23", 28, 2, 23);
    pulse("feb23_adv");
    load("ld_29feb24", 29, 2, 24);
    load("ld_31apr10", 31, 4, 10);
    load("ld_day0", 0, 5, 10);
    load("ld_month13", 15, 13, 10);
    load("ld_year100", 1, 1, 100);

    // Accepted load coinciding with the internal advance pulse.
    i_inc_day = 1'b1;
    tick();
    tick();
    i_set_valid = 1'b1;
    i_set_day   = 5'd15;
    i_set_month = 4'd6;
    i_set_year  = 7'd30;
    tick();
    i_set_valid = 1'b0;
    md = 15; mm = 6; my = 30;
    check("ld_vs_adv", 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    i_inc_day = 1'b0;
    repeat (3) tick();
    check("ld_vs_adv_noextra", 1'b0, 1'b0, 1'b0);

    // Rejected load coinciding with the advance pulse: advance still applies.
    i_inc_day = 1'b1;
    tick();
    tick();
    i_set_valid = 1'b1;
    i_set_day   = 5'd31;
    i_set_month = 4'd4;
    i_set_year  = 7'd10;
    tick();
    i_set_valid = 1'b0;
    model_adv(cen);
    check("rej_vs_adv", 1'b0, 1'b1, cen);
    i_inc_day = 1'b0;
    repeat (4) tick();
    check("rej_vs_adv_idle", 1'b0, 1'b0, 1'b0);

    // Reset one cycle after the edge; the held level must not advance later.
    load("ld_30nov05", 30, 11, 5);
    i_inc_day = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    md = 1; mm = 1; my = RST_Y;
    check("mid_rst", 1'b0, 1'b0, 1'b0);
    repeat (8) tick();
    check("mid_rst_hold", 1'b0, 1'b0, 1'b0);
    i_inc_day = 1'b0;
    repeat (4) tick();
    pulse("after_rst");

    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        load("rnd_ld_any", int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 127)));
      end else if (sel == 1) begin
        load("rnd_ld_end", int'($urandom_range(26, 31)), int'($urandom_range(1, 12)),
             int'($urandom_range(95, 99)));
        pulse("rnd_end_adv");
      end else begin
        pulse("rnd_adv");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
